// File: rtl/mdio_pkg.sv
// Shared types and frame constants for the MDIO (clause 22) management master.
package mdio_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_HDR, S_TA, S_DATA, S_IDLE_BIT, S_DONE
  } state_t;

  localparam logic [1:0] ST       = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam int HDR_BITS  = 14;
  localparam int TA_BITS   = 2;
  localparam int DATA_BITS = 16;

  // Index of the final bit period spent in a given state.
  function automatic logic [5:0] last_bit(input state_t s, input int pre_len);
    case (s)
      S_PRE:   last_bit = 6'(pre_len - 1);
      S_HDR:   last_bit = 6'(HDR_BITS - 1);
      S_TA:    last_bit = 6'(TA_BITS - 1);
      S_DATA:  last_bit = 6'(DATA_BITS - 1);
      default: last_bit = 6'd0;
    endcase
  endfunction

endpackage

// File: rtl/mdio_phy_master_if.sv
// Command/response and pad bundle of the MDIO master; master = the block, slave = requester/pad.
interface mdio_phy_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [4:0]  cmd_phy;
  logic [4:0]  cmd_reg;
  logic [15:0] cmd_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;
  logic        mdc;
  logic        mdio_in;
  logic        mdio_out;
  logic        mdio_oen;

  modport master (
    input  cmd_valid, cmd_write, cmd_phy, cmd_reg, cmd_wdata, mdio_in,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy, mdc, mdio_out, mdio_oen
  );
  modport slave (
    output cmd_valid, cmd_write, cmd_phy, cmd_reg, cmd_wdata, mdio_in,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy, mdc, mdio_out, mdio_oen
  );
endinterface

// File: rtl/mdc_clk_gen.sv
// MDC divider: low for CLK_DIV cycles then high for CLK_DIV, with strobes on the
// cycle before each edge so registered logic changes together with MDC.
module mdc_clk_gen #(
  parameter int CLK_DIV = 10
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_clr,
  output logic o_mdc,
  output logic o_fall_stb,
  output logic o_rise_stb
);
  localparam logic [8:0] HALF = 9'(CLK_DIV);
  localparam logic [8:0] RISE = 9'(CLK_DIV - 1);
  localparam logic [8:0] LAST = 9'(2 * CLK_DIV - 1);

  logic [8:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n || i_clr)  r_cnt <= '0;
    else if (r_cnt == LAST) r_cnt <= '0;
    else                    r_cnt <= r_cnt + 9'd1;
  end

  assign o_mdc      = (r_cnt >= HALF);
  assign o_fall_stb = !i_clr && (r_cnt == LAST);
  assign o_rise_stb = !i_clr && (r_cnt == RISE);
endmodule

// File: rtl/mdio_phy_master.sv
// MDIO management master: one clause-22 read or write frame per accepted command,
// single-cycle completion pulse with read data and turnaround error.
module mdio_phy_master
  import mdio_pkg::*;
#(
  parameter int CLK_DIV      = 10,
  parameter int PREAMBLE_LEN = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  mdio_phy_master_if.master bus
);
  state_t      r_state, w_state_nxt;
  logic        r_live;
  logic        r_wr;
  logic [31:0] r_tx;
  logic [5:0]  r_bits;
  logic [15:0] r_rdata;
  logic        r_err;
  logic        w_accept, w_clr, w_fall, w_rise, w_last;

  assign w_accept = bus.cmd_valid && bus.cmd_ready;
  // Divider held at zero outside a frame so each frame opens with a full MDC low half.
  assign w_clr    = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_last   = (r_bits == last_bit(r_state, PREAMBLE_LEN));

  mdc_clk_gen #(.CLK_DIV(CLK_DIV)) u_mdc (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_clr     (w_clr),
    .o_mdc     (bus.mdc),
    .o_fall_stb(w_fall),
    .o_rise_stb(w_rise)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:     if (w_accept) w_state_nxt = (PREAMBLE_LEN > 0) ? S_PRE : S_HDR;
      S_PRE:      if (w_fall && w_last) w_state_nxt = S_HDR;
      S_HDR:      if (w_fall && w_last) w_state_nxt = S_TA;
      S_TA:       if (w_fall && w_last) w_state_nxt = S_DATA;
      S_DATA:     if (w_fall && w_last) w_state_nxt = S_IDLE_BIT;
      S_IDLE_BIT: if (w_fall && w_last) w_state_nxt = S_DONE;
      S_DONE:     w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  // The whole outgoing frame after the preamble lives in r_tx; bit 31 is on the wire.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_live  <= 1'b0;
      r_wr    <= 1'b0;
      r_tx    <= '0;
      r_bits  <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_live <= 1'b1;
      if (w_accept) begin
        r_wr    <= bus.cmd_write;
        r_tx    <= {ST, bus.cmd_write ? OP_WRITE : OP_READ, bus.cmd_phy, bus.cmd_reg,
                    2'b10, bus.cmd_write ? bus.cmd_wdata : 16'h0000};
        r_bits  <= '0;
        r_rdata <= '0;
        r_err   <= 1'b0;
      end else if (w_fall) begin
        r_bits <= w_last ? 6'd0 : r_bits + 6'd1;
        if (r_state inside {S_HDR, S_TA, S_DATA}) r_tx <= {r_tx[30:0], 1'b0};
      end
      if (w_rise && !r_wr) begin
        if (r_state == S_TA && r_bits == 6'd1) r_err <= bus.mdio_in;
        if (r_state == S_DATA) r_rdata <= {r_rdata[14:0], bus.mdio_in};
      end
    end
  end

  always_comb begin
    bus.mdio_out = 1'b1;
    bus.mdio_oen = 1'b1;
    case (r_state)
      S_PRE: bus.mdio_oen = 1'b0;
      S_HDR: begin
        bus.mdio_oen = 1'b0;
        bus.mdio_out = r_tx[31];
      end
      S_TA, S_DATA: if (r_wr) begin
        bus.mdio_oen = 1'b0;
        bus.mdio_out = r_tx[31];
      end
      default: ;
    endcase
  end

  assign bus.cmd_ready = r_live && (r_state == S_IDLE);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.rsp_valid = (r_state == S_DONE);
  assign bus.rsp_rdata = r_rdata;
  assign bus.rsp_err   = r_err;
endmodule

// File: tb/tb_mdio_phy_master.sv
// Bench for mdio_phy_master: default instance (CLK_DIV=10, PREAMBLE_LEN=32) and a fast one (2, 0).
module tb_mdio_phy_master;

  typedef struct {
    bit          use_b;
    bit          wr;
    logic [4:0]  phy;
    logic [4:0]  rg;
    logic [15:0] wdata;
    bit          phy_on;
    bit          ta2;
    logic [15:0] pdata;
    logic [15:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  logic clk;
  logic reset_n;
  logic sel;
  logic d_valid, d_write, d_mdio_in;
  logic [4:0] d_phy, d_reg;
  logic [15:0] d_wdata;
  int total, bad;
  int r1, r2;
  logic rdy_gap, seen, quiet2;
  vec_t tbl[6];
  vec_t rv;
  logic [16:0] rr;

  mdio_phy_master_if bus_a();
  mdio_phy_master_if bus_b();

  mdio_phy_master #(.CLK_DIV(10), .PREAMBLE_LEN(32)) u_a (
    .clk(clk), .reset_n(reset_n), .bus(bus_a.master));
  mdio_phy_master #(.CLK_DIV(2), .PREAMBLE_LEN(0)) u_b (
    .clk(clk), .reset_n(reset_n), .bus(bus_b.master));

  assign bus_a.cmd_valid = d_valid & ~sel;
  assign bus_b.cmd_valid = d_valid & sel;
  assign bus_a.cmd_write = d_write;
  assign bus_b.cmd_write = d_write;
  assign bus_a.cmd_phy   = d_phy;
  assign bus_b.cmd_phy   = d_phy;
  assign bus_a.cmd_reg   = d_reg;
  assign bus_b.cmd_reg   = d_reg;
  assign bus_a.cmd_wdata = d_wdata;
  assign bus_b.cmd_wdata = d_wdata;
  assign bus_a.mdio_in   = d_mdio_in;
  assign bus_b.mdio_in   = d_mdio_in;

  logic m_ready, m_busy, m_rsp, m_err, m_mdc, m_out, m_oen;
  logic [15:0] m_rdata;
  assign m_ready = sel ? bus_b.cmd_ready : bus_a.cmd_ready;
  assign m_busy  = sel ? bus_b.busy      : bus_a.busy;
  assign m_rsp   = sel ? bus_b.rsp_valid : bus_a.rsp_valid;
  assign m_err   = sel ? bus_b.rsp_err   : bus_a.rsp_err;
  assign m_rdata = sel ? bus_b.rsp_rdata : bus_a.rsp_rdata;
  assign m_mdc   = sel ? bus_b.mdc       : bus_a.mdc;
  assign m_out   = sel ? bus_b.mdio_out  : bus_a.mdio_out;
  assign m_oen   = sel ? bus_b.mdio_oen  : bus_a.mdio_oen;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Completion a clause-22 PHY produces: {err, rdata}.
  function automatic logic [16:0] model_rsp(input vec_t v);
    if (v.wr)      return 17'h0;
    if (!v.phy_on) return {1'b1, 16'hFFFF};
    return {v.ta2, v.pdata};
  endfunction

  task automatic run_frame(input vec_t v, input int pulse_at);
    int d, p, n, c, lat, rises, k;
    logic [127:0] eo, eoen, care, ao, aoen, plan;
    logic [13:0] hdr;
    logic [17:0] tail;
    logic prev_mdc, tmg_ok, busy_ok, quiet, er;
    logic [15:0] rd;
    d = v.use_b ? 2 : 10;
    p = v.use_b ? 0 : 32;
    n = p + 33;
    eo = '0; eoen = '0; care = '0; ao = '0; aoen = '0; plan = '1;
    // Expected wire content per bit period, written out from the frame format.
    k = 0;
    for (int i = 0; i < p; i++) begin eo[k] = 1'b1; care[k] = 1'b1; k++; end
    hdr = {2'b01, v.wr ? 2'b01 : 2'b10, v.phy, v.rg};
    for (int i = 13; i >= 0; i--) begin eo[k] = hdr[i]; care[k] = 1'b1; k++; end
    tail = {2'b10, v.wdata};
    for (int i = 17; i >= 0; i--) begin
      if (v.wr) begin eo[k] = tail[i]; care[k] = 1'b1; end
      else eoen[k] = 1'b1;
      k++;
    end
    eo[k] = 1'b1; eoen[k] = 1'b1; care[k] = 1'b1;
    if (!v.wr && v.phy_on) begin
      plan[p+15] = v.ta2;
      for (int i = 0; i < 16; i++) plan[p+16+i] = v.pdata[15-i];
    end

    sel = v.use_b;
    d_mdio_in = 1'b1;
    @(negedge clk);
    c = 0;
    while (!m_ready && c < 200) begin @(negedge clk); c++; end
    d_valid = 1'b1; d_write = v.wr; d_phy = v.phy; d_reg = v.rg; d_wdata = v.wdata;
    @(negedge clk);
    d_valid = 1'b0; d_write = ~v.wr;
    d_phy = 5'($urandom); d_reg = 5'($urandom); d_wdata = 16'($urandom);
    c = 0; lat = -1; rises = 0; prev_mdc = 1'b0; tmg_ok = 1'b1; busy_ok = 1'b1;
    rd = '0; er = 1'b0;
    while (lat < 0 && c < n * 2 * d + 50) begin
      if (m_mdc && !prev_mdc) begin
        if (c != rises * 2 * d + d) tmg_ok = 1'b0;
        if (rises < 128) begin ao[rises] = m_out; aoen[rises] = m_oen; end
        rises++;
      end
      if (!m_mdc && rises < 128) d_mdio_in = plan[rises];
      if (!m_busy || m_ready) busy_ok = 1'b0;
      d_valid = (c == pulse_at);
      if (m_rsp) begin lat = c + 1; rd = m_rdata; er = m_err; end
      prev_mdc = m_mdc;
      if (lat < 0) begin @(negedge clk); c++; end
    end
    d_valid = 1'b0;
    check("latency", 128'(lat), 128'(n * 2 * d + 1));
    check("mdc timing", 128'(tmg_ok), 128'(1));
    check("busy and ready in frame", 128'(busy_ok), 128'(1));
    check("bit periods", 128'(rises), 128'(n));
    check("mdio_oen per bit", aoen, eoen);
    check("mdio_out per bit", ao & care, eo & care);
    check("rsp_rdata", 128'(rd), 128'(v.exp_rdata));
    check("rsp_err", 128'(er), 128'(v.exp_err));
    quiet = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (m_rsp || m_busy || !m_ready || m_mdc || !m_oen) quiet = 1'b0;
    end
    check("idle after done", 128'(quiet), 128'(1));
    d_mdio_in = 1'b1;
  endtask

  initial begin
    total = 0; bad = 0; sel = 1'b0;
    d_valid = 1'b0; d_write = 1'b0; d_phy = '0; d_reg = '0; d_wdata = '0; d_mdio_in = 1'b1;
    reset_n = 1'b0;

    tbl[0] = '{use_b:0, wr:1, phy:5'd1,  rg:5'd0,  wdata:16'h1140, phy_on:0, ta2:0,
               pdata:16'h0000, exp_rdata:16'h0000, exp_err:0};
    tbl[1] = '{use_b:0, wr:0, phy:5'd1,  rg:5'd2,  wdata:16'hDEAD, phy_on:1, ta2:0,
               pdata:16'h0022, exp_rdata:16'h0022, exp_err:0};
    tbl[2] = '{use_b:0, wr:0, phy:5'd1,  rg:5'd3,  wdata:16'h0000, phy_on:0, ta2:0,
               pdata:16'h0000, exp_rdata:16'hFFFF, exp_err:1};
    tbl[3] = '{use_b:0, wr:0, phy:5'h1F, rg:5'h1F, wdata:16'h0000, phy_on:1, ta2:1,
               pdata:16'hA5C3, exp_rdata:16'hA5C3, exp_err:1};
    tbl[4] = '{use_b:1, wr:1, phy:5'd3,  rg:5'd4,  wdata:16'hBEEF, phy_on:0, ta2:0,
               pdata:16'h0000, exp_rdata:16'h0000, exp_err:0};
    tbl[5] = '{use_b:1, wr:0, phy:5'h10, rg:5'h01, wdata:16'h7777, phy_on:1, ta2:0,
               pdata:16'h8001, exp_rdata:16'h8001, exp_err:0};

    // Reset state, then cmd_ready on the first edge out of reset.
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = (s == 1); #1;
      check("reset state", 128'({m_ready, m_busy, m_rsp, m_err, m_mdc, m_out, m_oen, m_rdata}),
            128'({7'b0000011, 16'h0000}));
    end
    reset_n = 1'b1;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = (s == 1); #1;
      check("ready after reset", 128'({m_ready, m_busy}), 128'(2'b10));
    end

    for (int i = 0; i < 6; i++) run_frame(tbl[i], -1);

    // Reset in the middle of a write frame.
    sel = 1'b0;
    @(negedge clk);
    d_valid = 1'b1; d_write = 1'b1; d_phy = 5'h07; d_reg = 5'h09; d_wdata = 16'h1234;
    @(negedge clk);
    d_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 399; i++) begin
      if (m_rsp) seen = 1'b1;
      @(negedge clk);
    end
    check("frame live before abort", 128'({m_busy, m_oen}), 128'(2'b10));
    reset_n = 1'b0;
    @(negedge clk);
    check("abort releases pad", 128'({m_oen, m_mdc, m_rsp, m_busy, m_ready}), 128'(5'b10000));
    check("abort gives no rsp", 128'(seen), 128'(0));
    reset_n = 1'b1;
    @(negedge clk);
    check("ready after abort", 128'(m_ready), 128'(1));

    // Command pulsed while busy must be dropped.
    run_frame('{use_b:0, wr:1, phy:5'h0A, rg:5'h11, wdata:16'h5A5A, phy_on:0, ta2:0,
                pdata:16'h0000, exp_rdata:16'h0000, exp_err:0}, 100);

    // cmd_valid held high: second accept on the IDLE cycle right after DONE.
    sel = 1'b1; d_mdio_in = 1'b1;
    @(negedge clk);
    d_valid = 1'b1; d_write = 1'b0; d_phy = 5'h02; d_reg = 5'h03;
    r1 = -1; r2 = -1; rdy_gap = 1'b0;
    for (int c = 0; c < 400 && r2 < 0; c++) begin
      @(negedge clk);
      if (r1 >= 0 && c == r1 + 1) rdy_gap = m_ready && !m_busy;
      if (m_rsp) begin
        if (r1 < 0) r1 = c;
        else begin r2 = c; d_valid = 1'b0; end
      end
    end
    d_valid = 1'b0;
    check("b2b first latency", 128'(r1 + 1), 128'(133));
    check("b2b spacing", 128'(r2 - r1), 128'(134));
    check("b2b ready gap", 128'(rdy_gap), 128'(1));
    quiet2 = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (m_busy || m_rsp) quiet2 = 1'b0;
    end
    check("b2b stops when valid drops", 128'(quiet2), 128'(1));

    // Randomized frames against the completion model.
    for (int i = 0; i < 8; i++) begin
      rv.use_b  = ($urandom_range(0, 2) != 0);
      rv.wr     = $urandom_range(0, 1) == 1;
      rv.phy    = 5'($urandom);
      rv.rg     = 5'($urandom);
      rv.wdata  = 16'($urandom);
      rv.phy_on = ($urandom_range(0, 3) != 0);
      rv.ta2    = ($urandom_range(0, 4) == 0);
      rv.pdata  = 16'($urandom);
      rr = model_rsp(rv);
      rv.exp_err   = rr[16];
      rv.exp_rdata = rr[15:0];
      run_frame(rv, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
